// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and helpers for the iterative ALU.
// The op encodings match the ALU controller's 4-bit Operation field.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_XOR = 4'b1001,
        OP_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: logic, add/sub and compares.
// Shift codes and unknown codes produce 0; shifts are handled iteratively by the top.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (Operation)
            OP_AND: result = SrcA & SrcB;
            OP_OR:  result = SrcA | SrcB;
            OP_ADD: result = SrcA + SrcB;
            OP_SUB: result = SrcA - SrcB;
            OP_XOR: result = SrcA ^ SrcB;
            OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_EQ:  result = {{(WIDTH-1){1'b0}}, (SrcA == SrcB)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// Multicycle execute-stage ALU: one-cycle logic/arith/compare ops, one-bit-per-cycle shifts.
// start/busy/done handshake; ALUResult and Zero are registered and held between completions.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    alu_state_e       state, state_nxt;
    alu_op_e          op_q, op_nxt;
    logic [WIDTH-1:0] work, work_nxt, shifted;
    logic [SHW-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0] comb_res, res_nxt;
    logic             res_we;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .Operation(Operation),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .result   (comb_res)
    );

    always_comb begin
        shifted = work;
        case (op_q)
            OP_SLL:  shifted = {work[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work[WIDTH-1:1]};
            OP_SRA:  shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            default: shifted = work;
        endcase
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        work_nxt  = work;
        cnt_nxt   = cnt;
        res_nxt   = ALUResult;
        res_we    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (start) begin
                    if (!is_shift(Operation)) begin
                        res_nxt   = comb_res;
                        res_we    = 1'b1;
                        state_nxt = S_DONE;
                    end else if (SrcB[SHW-1:0] == '0) begin
                        res_nxt   = SrcA;
                        res_we    = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        work_nxt  = SrcA;
                        cnt_nxt   = SrcB[SHW-1:0];
                        op_nxt    = alu_op_e'(Operation);
                        state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // start is deliberately not looked at here: requests during a shift are dropped
                work_nxt = shifted;
                cnt_nxt  = cnt - 1'b1;
                if (cnt == SHW'(1)) begin
                    res_nxt   = shifted;
                    res_we    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= OP_AND;
            work      <= '0;
            cnt       <= '0;
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
            work  <= work_nxt;
            cnt   <= cnt_nxt;
            if (res_we) begin
                ALUResult <= res_nxt;
                Zero      <= (res_nxt == '0);
            end
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: vector table with latency checks, a result
// scoreboard popped on done, and hand-written back-to-back / dropped-start / abort sequences.
module tb_alu_iterative;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  Operation;
    logic [31:0] SrcA, SrcB;
    logic        busy, done, Zero;
    logic [31:0] ALUResult;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    alu_iterative #(.WIDTH(32), .SHW(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .Operation(Operation),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .busy     (busy),
        .done     (done),
        .ALUResult(ALUResult),
        .Zero     (Zero)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) $display("FAIL %s: got %0h want %0h", nm, act, expv);
        else passed++;
    endfunction

    // scoreboard: every done must match the oldest accepted op
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", ALUResult, e);
                chk("zero flag", {31'd0, Zero}, {31'd0, (e == 32'd0)});
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat, input string nm);
        int got, bsy;
        @(negedge clk);
        start = 1'b1; Operation = op; SrcA = a; SrcB = b;
        @(posedge clk);
        exp_q.push_back(expv);
        #1;
        start = 1'b0; SrcA = $urandom; SrcB = $urandom; Operation = 4'($urandom);
        got = -1; bsy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin got = k; break; end
            if (busy) bsy++;
        end
        chk({nm, " latency"}, got, lat);
        chk({nm, " busy cycles"}, bsy, lat - 1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, expv;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int dcnt;
        logic [31:0] xa[4], xb[4];

        vecs.push_back('{OP_ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1,  "add wrap"});
        vecs.push_back('{OP_ADD, 32'hFFFFFFFF, 32'h1,        32'h0,        1,  "add carry out"});
        vecs.push_back('{OP_SUB, 32'd5,        32'd5,        32'h0,        1,  "sub zero"});
        vecs.push_back('{OP_SLT, 32'hFFFFFFFF, 32'h1,        32'h1,        1,  "slt neg"});
        vecs.push_back('{OP_SLT, 32'h1,        32'hFFFFFFFF, 32'h0,        1,  "slt pos"});
        vecs.push_back('{OP_EQ,  32'd3,        32'd3,        32'h1,        1,  "eq true"});
        vecs.push_back('{OP_EQ,  32'd3,        32'd4,        32'h0,        1,  "eq false"});
        vecs.push_back('{OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1,  "and"});
        vecs.push_back('{OP_OR,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1,  "or"});
        vecs.push_back('{4'b0110, 32'hFFFF,    32'h1,        32'h0,        1,  "unknown op"});
        vecs.push_back('{OP_SRA, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32, "sra 31"});
        vecs.push_back('{OP_SRL, 32'h80000000, 32'd31,       32'h00000001, 32, "srl 31"});
        vecs.push_back('{OP_SLL, 32'h1,        32'd4,        32'h10,       5,  "sll 4"});
        vecs.push_back('{OP_SLL, 32'hA5,       32'd0,        32'hA5,       1,  "sll 0"});
        vecs.push_back('{OP_SRA, 32'h70000000, 32'd4,        32'h07000000, 5,  "sra pos"});
        vecs.push_back('{OP_SRA, 32'h800000F0, 32'hFFFFFFE1, 32'hC0000078, 2,  "sra hi shamt bits"});

        reset = 1'b1; start = 1'b0; Operation = '0; SrcA = '0; SrcB = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle result", ALUResult, 32'h0);
            chk("idle busy/done/zero", {29'd0, busy, done, Zero}, 32'b001);
        end

        foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expv, vecs[i].lat, vecs[i].nm);

        // back-to-back XORs with start held high
        for (int i = 0; i < 4; i++) begin xa[i] = $urandom; xb[i] = $urandom; end
        xb[3] = xa[3];
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Operation = OP_XOR; SrcA = xa[i]; SrcB = xb[i];
            @(posedge clk);
            exp_q.push_back(xa[i] ^ xb[i]);
            @(negedge clk);
            chk("b2b done", {31'd0, done}, 32'd1);
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b idle after", {30'd0, busy, done}, 32'd0);

        // start pulsed mid-shift with new operands: must be dropped
        @(negedge clk);
        start = 1'b1; Operation = OP_SRL; SrcA = 32'hF0; SrcB = 32'd4;
        @(posedge clk);
        exp_q.push_back(32'h0F);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; Operation = OP_ADD; SrcA = 32'h1234; SrcB = 32'h5;
        @(negedge clk);
        start = 1'b0; SrcA = 32'hDEAD; SrcB = 32'h3; Operation = OP_SLL;
        dcnt = 0;
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("drop start done cycle", k, 5);
            end
        end
        chk("drop start done count", dcnt, 1);

        // reset mid-shift aborts without a done pulse
        @(negedge clk);
        start = 1'b1; Operation = OP_SLL; SrcA = 32'h3; SrcB = 32'd8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-abort busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort result", ALUResult, 32'h0);
        chk("abort busy/done/zero", {29'd0, busy, done, Zero}, 32'b001);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("abort no activity", dcnt, 0);
        issue(OP_ADD, 32'd2, 32'd3, 32'd5, 1, "post-reset add");
        issue(OP_SLL, 32'h3, 32'd8, 32'h300, 9, "post-reset sll 8");

        @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Multicycle execute-stage ALU that sits directly downstream of the ALU controller. It consumes the controller's 4-bit `Operation` code plus two 32-bit operands and produces a registered result. Logic, arithmetic and compare ops complete in one cycle. Shifts run iteratively, one bit per cycle, so no barrel shifter is needed. A start/busy/done handshake lets the pipeline stall while a shift is in flight.

## Interface
- `WIDTH`, 32: operand/result width.
- `SHW`, 5: shift-amount width, equal to log2(`WIDTH`).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `Operation`  in  4  op code from the ALU controller.
- `SrcA`  in  `WIDTH`  operand A / shift source.
- `SrcB`  in  `WIDTH`  operand B; bits [`SHW`-1:0] are the shift amount.
- `busy`  out  1  operation in flight; `start` is ignored while high.
- `done`  out  1  one-cycle pulse; `ALUResult` is valid on this cycle.
- `ALUResult`  out  `WIDTH`  registered result, held until the next completion.
- `Zero`  out  1  `ALUResult`==0, registered together with the result.

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 1001 XOR, 1100 SLT (signed, result 0/1), 1000 EQ (result 1 if A==B, else 0), 0100 SLL, 0101 SRL, 0111 SRA.
- Any other code completes in one cycle with `ALUResult`=0 and `Zero`=1.
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE with `start` and a non-shift op: compute combinationally, register the result, go to DONE.
- IDLE with `start` and a shift op, shamt=0: register `SrcA` unchanged, go to DONE.
- IDLE with `start` and a shift op, shamt=n>0: load `SrcA` into the work register, load the counter with n, latch the op, go to SHIFT.
- SHIFT: each cycle shift the work register by 1 and decrement the counter.
  - SLL fills with 0; SRL fills with 0; SRA replicates the MSB.
  - When the counter goes from 1 to 0, copy the work register to `ALUResult` and go to DONE.
- DONE: `done`=1 for this cycle only. If `start`=1, accept it exactly as from IDLE (back-to-back). Otherwise go to IDLE.
- `busy`=1 only in SHIFT. `start` during SHIFT is dropped, not queued.
- Operands are sampled only at acceptance. Changes to `SrcA`, `SrcB` or `Operation` afterwards have no effect on the op in flight.
- ADD/SUB wrap modulo 2^`WIDTH`; no flags other than `Zero`.

## Timing
- Reset values (asynchronous): state=IDLE, `busy`=0, `done`=0, `ALUResult`=0, `Zero`=1, counter=0.
- Count cycles from the accepting edge, taken as cycle 0.
- Non-shift op, or shift with shamt=0: `done`=1 in cycle 1.
- Shift with shamt=n>0: `busy`=1 in cycles 1..n, `done`=1 in cycle n+1.
- Maximum latency is 32 cycles (shamt=31).
- Throughput with back-to-back starts: one non-shift op per cycle.
- `reset` asserted mid-shift aborts immediately. No `done` pulse is produced and outputs return to their reset values.

## Structure
- Shared package `alu_pkg`:
  - enum `alu_op_e` listing the codes above;
  - FSM state enum;
  - helper function `is_shift(op)`.
- One sub-module, `alu_comb`: purely combinational single-cycle datapath. It takes (`Operation`, `SrcA`, `SrcB`) and produces the result.
- The top level owns the FSM, the shift work register and counter, and the result/`Zero` registers.

## Test plan
- Reset then idle: `ALUResult`=0, `Zero`=1, `busy`=0 and `done`=0 for 5 cycles with `start`=0.
- ADD 0x7FFFFFFF+1 -> 0x80000000 in cycle 1. SUB 5-5 -> 0 with `Zero`=1. SLT -1,1 -> 1. EQ 3,3 -> 1.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF with `done` in cycle 32. SRL of the same value by 31 -> 0x00000001. SLL 1 by 4 -> 0x10 with `done` in cycle 5.
- Shift by 0: SLL 0xA5 -> 0xA5 with `done` in cycle 1. Next, `start` held high with back-to-back XOR ops: one `done` per cycle with correct results.
- `start` pulsed and operands changed during SRL 0xF0 by 4: the extra start is ignored and the result is 0x0F.
- `reset` asserted during SHIFT at cycle 3 of an 8-bit shift: outputs return to reset values and no `done` pulse occurs. A new op after reset completes correctly.
